// File: rtl/hdr_tone_map_if.sv
// Pixel-side bundle of the HDR tone mapper: log-radiance in, RGB565 out.
// With TM_STATS_EN defined, the latched frame statistics are carried too.
interface hdr_tone_map_if #(parameter int N = 12);
  logic [N-1:0] lE_red, lE_green, lE_blue;
  logic         hdr_done, frame_end;
  logic [4:0]   red_out, blue_out;
  logic [5:0]   green_out;
  logic         tm_valid, busy;
`ifdef TM_STATS_EN
  logic [N-1:0] stat_min, stat_max;
  logic         stat_valid;

  modport master (output lE_red, lE_green, lE_blue, hdr_done, frame_end,
                  input  red_out, green_out, blue_out, tm_valid, busy,
                         stat_min, stat_max, stat_valid);
  modport slave  (input  lE_red, lE_green, lE_blue, hdr_done, frame_end,
                  output red_out, green_out, blue_out, tm_valid, busy,
                         stat_min, stat_max, stat_valid);
`else
  modport master (output lE_red, lE_green, lE_blue, hdr_done, frame_end,
                  input  red_out, green_out, blue_out, tm_valid, busy);
  modport slave  (input  lE_red, lE_green, lE_blue, hdr_done, frame_end,
                  output red_out, green_out, blue_out, tm_valid, busy);
`endif
endinterface

// File: rtl/hdr_tone_map.sv
// hdr_tone_map: normalises Q4.8 log-radiance against the previous frame's min/max -> RGB565.
// Optional TM_STATS_EN exposes the latched frame min/max with a one-cycle stat_valid strobe.

module hdr_tm_lane #(
  parameter int N     = 12,
  parameter int FP    = 8,
  parameter int DIV_W = 17,
  parameter int OW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_s1,
  input  logic             load_out,
  input  logic [N-1:0]     le,
  input  logic [N-1:0]     act_min,
  input  logic [DIV_W-1:0] scale,
  input  logic             flat,
  output logic [OW-1:0]    out
);
  localparam int PW = N + DIV_W;

  logic [N-1:0]  d_q;
  logic [PW-1:0] p, qo;
  logic [OW-1:0] out_c;

  always_ff @(posedge clk)
    if (rst)          d_q <= '0;
    else if (load_s1) d_q <= (le < act_min) ? '0 : le - act_min;

  assign p = {{DIV_W{1'b0}}, d_q} * {{N{1'b0}}, scale};
  // Shifting straight to the output width: saturation of the 8-bit norm
  // is the same test as any bit set above the OW-bit field.
  assign qo = p >> (FP + 8 - OW);

  always_comb begin
    if (flat)                out_c = {1'b1, {(OW-1){1'b0}}};
    else if (|qo[PW-1:OW])   out_c = '1;
    else                     out_c = qo[OW-1:0];
  end

  always_ff @(posedge clk)
    if (rst)           out <= '0;
    else if (load_out) out <= out_c;
endmodule

module hdr_tone_map #(
  parameter int N     = 12,
  parameter int FP    = 8,
  parameter int DIV_W = 17
) (
  input  logic          clk,
  input  logic          rst,
  hdr_tone_map_if.slave io
);
  localparam int NL     = 3;
  localparam int STAGES = 1;   // vld_pipe[0] = S1 valid, vld_pipe[STAGES] = tm_valid
  localparam int CW     = $clog2(DIV_W);

  typedef enum logic [1:0] {IDLE, DIVIDE, UPDATE} state_t;
  state_t state_q, state_d;

  logic                    busy, upd, accept;
  logic [STAGES:0]         vld_pipe;
  logic [NL-1:0][N-1:0]    le;
  logic [N-1:0]            px_min, px_max, m_min, m_max;
  logic [N-1:0]            run_min, run_max, lat_min, lat_max, act_min;
  logic                    run_cnt, m_cnt, lat_flat, act_flat, s1_flat;
  logic [DIV_W-1:0]        act_scale, s1_scale, quo, dvd;
  logic [N-1:0]            rem;
  logic [N:0]              rem_sh, range_w;
  logic                    ge;
  logic [CW-1:0]           div_cnt;

  assign le = {io.lE_blue, io.lE_green, io.lE_red};

  // Frame stats are shared across channels so colour balance is preserved.
  always_comb begin
    px_min = le[0];
    px_max = le[0];
    for (int i = 1; i < NL; i++) begin
      if (le[i] < px_min) px_min = le[i];
      if (le[i] > px_max) px_max = le[i];
    end
    m_min = (io.hdr_done && px_min < run_min) ? px_min : run_min;
    m_max = (io.hdr_done && px_max > run_max) ? px_max : run_max;
    m_cnt = run_cnt | io.hdr_done;
  end

  assign accept = (state_q == IDLE) && io.frame_end;

  // FSM: state register
  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (io.frame_end && m_cnt) state_d = (m_min == m_max) ? UPDATE : DIVIDE;
      DIVIDE:  if (div_cnt == CW'(DIV_W-1)) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = 1'b0;
    upd  = 1'b0;
    case (state_q)
      DIVIDE:  busy = 1'b1;
      UPDATE:  begin busy = 1'b1; upd = 1'b1; end
      default: ;
    endcase
  end

  // Running stats; a frame_end ignored while busy leaves them to merge into the next frame.
  always_ff @(posedge clk)
    if (rst || accept) begin
      run_min <= '1;
      run_max <= '0;
      run_cnt <= 1'b0;
    end else if (io.hdr_done) begin
      run_min <= m_min;
      run_max <= m_max;
      run_cnt <= 1'b1;
    end

  always_ff @(posedge clk)
    if (rst) begin
      lat_min  <= '0;
      lat_max  <= '0;
      lat_flat <= 1'b0;
    end else if (accept && m_cnt) begin
      lat_min  <= m_min;
      lat_max  <= m_max;
      lat_flat <= (m_min == m_max);
    end

  // Restoring divide of 2^16 by the range, one quotient bit per DIVIDE cycle.
  assign range_w = {1'b0, lat_max - lat_min};
  assign rem_sh  = {rem, dvd[DIV_W-1]};
  assign ge      = (rem_sh >= range_w);

  always_ff @(posedge clk)
    if (rst) begin
      rem     <= '0;
      quo     <= '0;
      dvd     <= '0;
      div_cnt <= '0;
    end else if (accept) begin
      rem     <= '0;
      quo     <= '0;
      dvd     <= {1'b1, {(DIV_W-1){1'b0}}};
      div_cnt <= '0;
    end else if (state_q == DIVIDE) begin
      rem     <= ge ? N'(rem_sh - range_w) : N'(rem_sh);
      quo     <= {quo[DIV_W-2:0], ge};
      dvd     <= dvd << 1;
      div_cnt <= div_cnt + 1'b1;
    end

  always_ff @(posedge clk)
    if (rst) begin
      act_min   <= '0;
      act_scale <= DIV_W'(16);
      act_flat  <= 1'b0;
    end else if (upd) begin
      act_min   <= lat_min;
      if (!lat_flat) act_scale <= quo;
      act_flat  <= lat_flat;
    end

  // Scale/flat travel with the pixel so S2 never mixes an old and new set.
  always_ff @(posedge clk)
    if (rst) begin
      s1_scale <= DIV_W'(16);
      s1_flat  <= 1'b0;
    end else if (io.hdr_done) begin
      s1_scale <= act_scale;
      s1_flat  <= act_flat;
    end

  always_ff @(posedge clk)
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[STAGES-1:0], io.hdr_done};

  for (genvar g = 0; g < NL; g++) begin : g_lane
    localparam int OW = (g == 1) ? 6 : 5;
    logic [OW-1:0] lane_out;

    hdr_tm_lane #(.N(N), .FP(FP), .DIV_W(DIV_W), .OW(OW)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load_s1  (io.hdr_done),
      .load_out (vld_pipe[0]),
      .le       (le[g]),
      .act_min  (act_min),
      .scale    (s1_scale),
      .flat     (s1_flat),
      .out      (lane_out)
    );

    if (g == 0)      begin : g_r assign io.red_out   = lane_out; end
    else if (g == 1) begin : g_g assign io.green_out = lane_out; end
    else             begin : g_b assign io.blue_out  = lane_out; end
  end

  assign io.tm_valid = vld_pipe[STAGES];
  assign io.busy     = busy;

`ifdef TM_STATS_EN
  logic [N-1:0] stat_min_q, stat_max_q;
  logic         stat_valid_q;

  // Registered together so the strobe and the values it qualifies line up.
  always_ff @(posedge clk)
    if (rst) begin
      stat_min_q   <= '0;
      stat_max_q   <= '0;
      stat_valid_q <= 1'b0;
    end else begin
      stat_valid_q <= upd;
      if (upd) begin
        stat_min_q <= lat_min;
        stat_max_q <= lat_max;
      end
    end

  assign io.stat_min   = stat_min_q;
  assign io.stat_max   = stat_max_q;
  assign io.stat_valid = stat_valid_q;
`endif
endmodule

// File: tb/tb_hdr_tone_map.sv
// Randomised bench for hdr_tone_map against a frame-level arithmetic reference model.
module tb_hdr_tone_map;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hdr_tone_map_if io();
  hdr_tone_map dut (.clk(clk), .rst(rst), .io(io.slave));

  int checks = 0;
  int errors = 0;
  bit armed  = 0;

  // reference model state
  int edge_k;
  int m_min, m_scale;  bit m_flat;
  int run_min, run_max; bit seen;
  bit inflight; int upd_edge;
  int n_min, n_max, n_scale; bit n_flat;
  bit s1_v; int s1_n [3];
  bit o_v;  int o_r, o_g, o_b;
  bit sv;   int s_min, s_max;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, act, exp, edge_k);
    end
  endtask

  function automatic int tmap(input int le);
    int d, n;
    d = (le < m_min) ? 0 : le - m_min;
    if (m_flat) return 128;
    n = (d * m_scale) / 256;
    return (n > 255) ? 255 : n;
  endfunction

  task automatic model_reset();
    m_min = 0; m_scale = 16; m_flat = 0;
    run_min = 4095; run_max = 0; seen = 0;
    inflight = 0; upd_edge = -1;
    s1_v = 0; o_v = 0; o_r = 0; o_g = 0; o_b = 0;
    sv = 0; s_min = 0; s_max = 0;
  endtask

  task automatic model_edge(input bit hd, input bit fe, input int r, input int g, input int b, input bit rs);
    bit acc;
    edge_k++;
    if (rs) begin model_reset(); return; end
    o_v = s1_v;
    if (s1_v) begin o_r = s1_n[0] / 8; o_g = s1_n[1] / 4; o_b = s1_n[2] / 8; end
    s1_v = hd;
    if (hd) begin s1_n[0] = tmap(r); s1_n[1] = tmap(g); s1_n[2] = tmap(b); end
    acc = fe && !inflight;
    sv = 0;
    if (inflight && edge_k == upd_edge) begin
      m_min = n_min;
      if (!n_flat) m_scale = n_scale;
      m_flat = n_flat;
      inflight = 0;
      sv = 1; s_min = n_min; s_max = n_max;
    end
    if (hd) begin
      foreach (s1_n[i]) ;
      if (r < run_min) run_min = r;  if (g < run_min) run_min = g;  if (b < run_min) run_min = b;
      if (r > run_max) run_max = r;  if (g > run_max) run_max = g;  if (b > run_max) run_max = b;
      seen = 1;
    end
    if (acc) begin
      if (seen) begin
        n_min = run_min; n_max = run_max;
        n_flat = (run_min == run_max);
        n_scale = n_flat ? 0 : 65536 / (run_max - run_min);
        inflight = 1;
        upd_edge = edge_k + (n_flat ? 1 : 18);
      end
      run_min = 4095; run_max = 0; seen = 0;
    end
  endtask

  task automatic check_out();
    chk("tm_valid", 32'(io.tm_valid), 32'(o_v));
    chk("red_out", 32'(io.red_out), o_r);
    chk("green_out", 32'(io.green_out), o_g);
    chk("blue_out", 32'(io.blue_out), o_b);
    chk("busy", 32'(io.busy), 32'(inflight));
`ifdef TM_STATS_EN
    chk("stat_valid", 32'(io.stat_valid), 32'(sv));
    chk("stat_min", 32'(io.stat_min), s_min);
    chk("stat_max", 32'(io.stat_max), s_max);
`endif
  endtask

  task automatic cyc(input bit hd, input bit fe, input int r, input int g, input int b, input bit rs);
    @(negedge clk);
    if (armed) check_out();
    rst = rs;
    io.hdr_done = hd; io.frame_end = fe;
    io.lE_red = 12'(r); io.lE_green = 12'(g); io.lE_blue = 12'(b);
    @(posedge clk);
    model_edge(hd, fe, r, g, b, rs);
    armed = 1;
  endtask

  task automatic px(input int r, input int g, input int b);  cyc(1, 0, r, g, b, 0); endtask
  task automatic idle(input int n);  for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0); endtask
  task automatic fend();  cyc(0, 1, 0, 0, 0, 0); endtask

  function automatic int rv(input int lo, input int hi);
    return $urandom_range(hi, lo);
  endfunction

  initial begin
    edge_k = 0;
    model_reset();
    io.hdr_done = 0; io.frame_end = 0;
    io.lE_red = '0; io.lE_green = '0; io.lE_blue = '0;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    idle(2);

    // default mapping straight out of reset
    px(12'h800, 12'h800, 12'h800);
    idle(3);

    // frame spanning 0x100..0x500, then probe the new scale
    px(12'h100, 12'h300, 12'h200);
    for (int i = 0; i < 6; i++) px(rv(256, 1280), rv(256, 1280), rv(256, 1280));
    px(12'h400, 12'h500, 12'h180);
    fend();
    idle(19);
    px(12'h300, 12'h300, 12'h300);
    px(12'h500, 12'h500, 12'h500);
    px(12'h080, 12'h080, 12'h080);
    px(12'hFFF, 12'h000, 12'h100);
    idle(3);

    // flat frame
    for (int i = 0; i < 4; i++) px(12'h400, 12'h400, 12'h400);
    fend();
    idle(2);
    for (int i = 0; i < 4; i++) px(rv(0, 4095), rv(0, 4095), rv(0, 4095));
    idle(2);

    // empty frame: no recompute, mapping unchanged
    fend();
    idle(2);
    for (int i = 0; i < 3; i++) px(rv(0, 4095), rv(0, 4095), rv(0, 4095));
    idle(2);

    // stream through a recompute, second frame_end at T+5 ignored
    for (int i = 0; i < 5; i++) px(rv(200, 900), rv(200, 900), rv(200, 900));
    cyc(1, 1, 12'h0C8, 12'h384, 12'h200, 0);
    for (int i = 1; i <= 22; i++)
      cyc(1, i == 5, rv(1000, 3000), rv(1000, 3000), rv(1000, 3000), 0);
    idle(2);
    fend();
    idle(20);
    px(12'h800, 12'hBB8, 12'h3E8);
    idle(3);

    // reset mid-divide
    for (int i = 0; i < 4; i++) px(rv(0, 2000), rv(0, 2000), rv(0, 2000));
    fend();
    idle(7);
    cyc(1, 0, 12'h123, 12'h456, 12'h789, 1);
    px(12'h800, 12'h800, 12'h800);
    idle(4);

    // random traffic: varying dynamic range, occasional resets
    begin
      int base, span;
      base = 1000; span = 500;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 39) == 0) begin
          base = rv(0, 4095);
          case ($urandom_range(0, 3))
            0: span = 0;
            1: span = 3;
            2: span = 300;
            default: span = 4095;
          endcase
        end
        cyc($urandom_range(0, 1) == 1,
            $urandom_range(0, 24) == 0,
            (base + rv(0, span)) % 4096, (base + rv(0, span)) % 4096, (base + rv(0, span)) % 4096,
            $urandom_range(0, 299) == 0);
      end
    end
    idle(22);
    @(negedge clk);
    check_out();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hdr_tone_map.md
Name: hdr_tone_map

Overview:
- Downstream stage of the HDR merge. Consumes per-pixel log-radiance triplets (lE, unsigned Q4.8, 12 bit) with their done strobe and produces RGB565 display pixels.
- Each value is normalised against the previous frame's global log-radiance min/max.
- Per-frame statistics are accumulated on the fly. At each frame end a serial divider computes the scale factor, which is swapped in atomically before the next frame.

Parameters:
- N, 12, log-radiance word width (Q4.8)
- FP, 8, fractional bits of lE
- DIV_W, 17, scale/divider width (quotient range 16..65536)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- lE_red  input  12  red log-radiance
- lE_green  input  12  green log-radiance
- lE_blue  input  12  blue log-radiance
- hdr_done  input  1  lE_* valid this cycle
- frame_end  input  1  single-cycle pulse; last pixel of frame has been (or is now being) presented
- red_out  output  5  tone-mapped red
- green_out  output  6  tone-mapped green
- blue_out  output  5  tone-mapped blue
- tm_valid  output  1  outputs valid this cycle
- busy  output  1  scale recomputation in progress

Behaviour:
- Reset: outputs 0, tm_valid=0, busy=0, state IDLE. Running stats reset: run_min=4095, run_max=0, run_cnt=0. Active set: act_min=0, act_scale=16, act_flat=0, so norm = lE>>4.
- Statistics:
  - On each hdr_done, run_min/run_max are updated with the min/max of all three channels. Stats are shared across channels to preserve colour balance.
  - run_cnt is a saturating 1-bit "seen a pixel" flag.
- Pixel pipeline, fixed 2-cycle latency; tm_valid = hdr_done delayed 2 cycles; no backpressure.
  - S1, per channel: d = (lE < act_min) ? 0 : lE - act_min (12 bit).
  - S2: p = d*act_scale (29 bit); norm = p>>8, saturated to 255. If act_flat, norm=128.
  - Output register: red_out=norm[7:3], green_out=norm[7:2], blue_out=norm[7:3].
  - Between valids, outputs hold their last values.
- FSM IDLE -> DIVIDE -> UPDATE -> IDLE.
  - IDLE, frame_end=1: latch lat_min=run_min, lat_max=run_max, lat_cnt=run_cnt, including any hdr_done pixel in the same cycle. Then clear running stats.
    - lat_cnt=0: stay IDLE; active set unchanged.
    - lat_max==lat_min: go UPDATE with flat=1.
    - Otherwise: range=lat_max-lat_min; go DIVIDE.
  - DIVIDE: restoring division 65536/range, one quotient bit per cycle, exactly 17 cycles; busy=1.
  - UPDATE, 1 cycle, busy=1: act_min=lat_min, act_scale=quotient (or unchanged if flat), act_flat=flat. Pixels entering S1 from the next cycle use the new set.
  - The active set changes only in UPDATE. S1/S2 always use one consistent set per pixel.
- Timing for frame_end sampled at edge T: DIVIDE occupies T+1..T+17, UPDATE T+18, busy high T+1..T+18, new set applies to hdr_done sampled at T+19 or later.
- Pixels arriving during DIVIDE/UPDATE are processed with the old set and accumulate into the new frame's running stats.
- frame_end while busy: ignored. Running stats are not cleared, so those pixels merge into the following frame.
- rst mid-DIVIDE: abort; return to full reset state, including the active set; pipeline valids flushed.

Optional Feature:
- TM_STATS_EN defined:
  - Adds output ports stat_min[11:0] and stat_max[11:0], registered from lat_min/lat_max in UPDATE, reset to 0.
  - Adds stat_valid, a 1-cycle pulse in UPDATE.
- TM_STATS_EN undefined: those ports and registers do not exist; core behaviour is identical.

Test Plan:
- After rst, hdr_done with all lE=0x800 -> 2 cycles later tm_valid=1, red_out=16, green_out=32, blue_out=16; busy=0.
- Frame of pixels spanning 0x100..0x500, then frame_end -> busy for 18 cycles, then act_scale=64. Next pixel: lE=0x300 -> red 16 / green 32; lE=0x500 -> red 31 / green 63; lE=0x080 -> red 0 / green 0.
- Frame with every channel 0x400, frame_end -> flat mode; any later pixel -> red 16, green 32, blue 16.
- frame_end with no pixels since last latch -> stays IDLE, busy=0, and the previous mapping is reproduced exactly.
- Pixels streamed during DIVIDE plus a second frame_end at T+5:
  - pixels at T+5..T+18 map with the old set, and the second frame_end is ignored;
  - pixel at T+19 uses the new set;
  - the next frame_end latches stats including those streamed pixels.
- rst asserted at T+8 mid-DIVIDE -> busy=0 next cycle, act_scale=16, lE=0x800 maps to red 16. With TM_STATS_EN, stat_valid pulses once in UPDATE with stat_min=0x100, stat_max=0x500 for the frame in the second scenario.
